freq_meter: RTL and testbench
=============================

// Module: freq_meter
// PURPOSE
//   Measures the frequency of an asynchronous input by counting its rising edges over a fixed gate window.
//   The window is timed from the F_OSC pixel clock, and the count is reported once per window.
//   This is the inverse of the clock prescaler: that block produces a known frequency, this one measures an unknown one.
//   Used for on-board self-check of the prescaled clocks and external sync inputs; sits in the clkin domain.
// PARAMETERS
//   F_OSC    25175000  clkin frequency in Hz
//   GATE_HZ  10        gate windows per second; gate length GATE_CYC = F_OSC/GATE_HZ (integer division), must be >= 2
//   CNT_W    24        width of edge counter and result; saturates at 2^CNT_W-1
// PORTS
//   clkin       in   1      system clock, all logic on posedge
//   rst_n       in   1      asynchronous active-low reset
//   sigin       in   1      signal to measure, asynchronous to clkin
//   enable      in   1      1 = measure continuously, 0 = stop/abort
//   count       out  CNT_W  rising edges seen in last completed window (Hz = count*GATE_HZ)
//   count_valid out  1      one-cycle pulse: count updated this cycle
//   overflow    out  1      last completed window saturated the counter
//   busy        out  1      1 while in MEASURE
// BEHAVIOUR
//   Reset (async, rst_n=0): count=0, count_valid=0, overflow=0, busy=0, state=IDLE.
//     Gate counter and edge counter are cleared to 0. Sync chain s1,s2,s3 is set to 1.
//   Input sync: s1<=sigin, s2<=s1, s3<=s2 every cycle in all states. edge = s2 & ~s3.
//     A sigin rise is seen as edge exactly 2 clkin cycles after it is registered in s1.
//     If sigin is held high through reset release, no edge is produced.
//     Max measurable rate is F_OSC/2; no further filtering.
//   FSM states: IDLE, MEASURE.
//     IDLE: busy=0. Gate counter and edge counter are held at 0.
//       enable=1 -> MEASURE next cycle.
//     MEASURE: busy=1. Gate counter gc runs 0..GATE_CYC-1, incrementing once per cycle.
//       Each cycle with edge=1 increments the edge counter ec, saturating at max.
//       Any increment attempt at max sets internal ovf_acc.
//     Window end (gc==GATE_CYC-1 with enable=1), in that same clock edge:
//       - count <= ec + edge (saturating); overflow <= ovf_acc or saturation on this add; count_valid <= 1.
//       - gc <= 0, ec <= 0, ovf_acc <= 0. State stays MEASURE, so the next window starts with no dead cycle.
//       - An edge in the last window cycle counts in the closing window only.
//     Latency: count_valid is high in the cycle after the last gate cycle; the first result comes GATE_CYC+1 cycles after leaving IDLE.
//     count and overflow hold their values until the next window end; count_valid is 0 otherwise.
//   enable=0 in MEASURE: go to IDLE next cycle and discard the partial window.
//     No count_valid; count and overflow are kept.
//     If enable falls in the window-end cycle, enable=0 wins: no result.
//   enable re-asserted: a fresh full window always starts.
//   Reset mid-window: immediate return to the reset values listed above.
//   Arithmetic: all counters unsigned. gc width is clog2(GATE_CYC).
//     GATE_CYC must fit in 32 bits; elaboration fails if GATE_CYC < 2.
// TESTING (bench uses F_OSC=1000, GATE_HZ=10 -> GATE_CYC=100, CNT_W=8 unless stated)
//   1. Reset with sigin=1, enable=1, hold sigin=1 -> after 101 cycles count_valid pulses with count=0, overflow=0.
//   2. sigin = clkin/10 square wave, enable=1 -> every 100 cycles count_valid, count=10 (+-1 on first window only), no gaps.
//   3. sigin = clkin/2 toggle, CNT_W=5 -> count=31, overflow=1. Then sigin slowed to clkin/10 -> next window count=10, overflow=0.
//   4. Single sigin pulse timed so edge hits gc==99 -> counted in that window (count=1), next window count=0.
//   5. enable dropped at gc==50 -> busy=0 next cycle, no count_valid, count keeps old value.
//      Re-enable -> first count_valid exactly 101 cycles later.
//   6. rst_n pulsed low mid-window with count=10 held -> count=0, busy=0 asynchronously.
//      With enable high, measuring resumes 1 cycle after release.

Source files
------------

// File: rtl/freq_meter.sv
// freq_meter
//   Counts rising edges of an asynchronous input over a fixed gate window
//   timed from clkin, and reports the count once per window. Windows run
//   back to back while enable is high. The edge count saturates at its
//   maximum value, and overflow records that saturation.
//
// Ports
//   clkin        in   system clock, all logic on posedge
//   rst_n        in   asynchronous active-low reset
//   sigin        in   signal to measure, asynchronous to clkin
//   enable       in   1 = measure continuously, 0 = stop/abort
//   count        out  rising edges seen in the last completed window
//   count_valid  out  one-cycle pulse when count is updated
//   overflow     out  last completed window saturated the counter
//   busy         out  1 while measuring
module freq_meter #(
    parameter int unsigned F_OSC   = 25175000,
    parameter int unsigned GATE_HZ = 10,
    parameter int unsigned CNT_W   = 24
) (
    input  logic             clkin,
    input  logic             rst_n,
    input  logic             sigin,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             count_valid,
    output logic             overflow,
    output logic             busy
);

    localparam int unsigned      GATE_CYC = F_OSC / GATE_HZ;
    localparam int unsigned      GC_W     = (GATE_CYC < 2) ? 1 : $clog2(GATE_CYC);
    localparam logic [GC_W-1:0]  GC_LAST  = GC_W'(GATE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    if (GATE_CYC < 2) begin : g_gate_check
        $error("freq_meter: gate length F_OSC/GATE_HZ must be at least 2");
    end

    typedef enum logic {
        IDLE,
        MEASURE
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             r_s1;
    logic             r_s2;
    logic             r_s3;
    logic             w_edge;
    logic [GC_W-1:0]  r_gc;
    logic [CNT_W-1:0] r_ec;
    logic             r_ovf_acc;
    logic             w_run;
    logic             w_win_end;
    logic [CNT_W:0]   w_sum;

    // Sync chain resets to 1 so a sigin held high through reset release
    // does not look like a fresh rising edge.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
            r_s3 <= 1'b1;
        end else begin
            r_s1 <= sigin;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_edge = r_s2 & ~r_s3;

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (enable)  w_state_next = MEASURE;
            MEASURE: if (!enable) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    assign w_run     = (r_state == MEASURE) && enable;
    assign w_win_end = w_run && (r_gc == GC_LAST);
    // Carry out of this add marks saturation caused by the closing edge.
    assign w_sum     = {1'b0, r_ec} + {{CNT_W{1'b0}}, w_edge};
    assign busy      = (r_state == MEASURE);

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            r_gc        <= '0;
            r_ec        <= '0;
            r_ovf_acc   <= 1'b0;
            count       <= '0;
            overflow    <= 1'b0;
            count_valid <= 1'b0;
        end else begin
            count_valid <= 1'b0;
            if (w_win_end) begin
                // Edge in the last gate cycle belongs to the closing window.
                count       <= w_sum[CNT_W] ? CNT_MAX : w_sum[CNT_W-1:0];
                overflow    <= r_ovf_acc | w_sum[CNT_W];
                count_valid <= 1'b1;
                r_gc        <= '0;
                r_ec        <= '0;
                r_ovf_acc   <= 1'b0;
            end else if (w_run) begin
                r_gc <= r_gc + GC_W'(1);
                if (w_edge) begin
                    if (r_ec == CNT_MAX) begin
                        r_ovf_acc <= 1'b1;
                    end else begin
                        r_ec <= r_ec + CNT_W'(1);
                    end
                end
            end else begin
                // Idle, or aborting: any partial window is discarded.
                r_gc      <= '0;
                r_ec      <= '0;
                r_ovf_acc <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_freq_meter.sv
module tb_freq_meter;

    localparam int unsigned GATE = 100;

    typedef struct {
        int unsigned n;
        int unsigned due;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sigin = 1'b1;
    logic       enable = 1'b1;
    logic [7:0] count8;
    logic       v8, ovf8, busy8;
    logic [4:0] count5;
    logic       v5, ovf5, busy5;

    int unsigned errors = 0;
    int unsigned checks = 0;

    // model state
    int unsigned cyc = 0;
    int unsigned ws = 0;
    bit          in_win = 0;
    bit          prev_s = 1;
    int unsigned rises[$];
    exp_t        q8[$];
    exp_t        q5[$];

    always #5 clk = ~clk;

    freq_meter #(.F_OSC(1000), .GATE_HZ(10), .CNT_W(8)) dut8 (
        .clkin(clk), .rst_n(rst_n), .sigin(sigin), .enable(enable),
        .count(count8), .count_valid(v8), .overflow(ovf8), .busy(busy8)
    );

    freq_meter #(.F_OSC(1000), .GATE_HZ(10), .CNT_W(5)) dut5 (
        .clkin(clk), .rst_n(rst_n), .sigin(sigin), .enable(enable),
        .count(count5), .count_valid(v5), .overflow(ovf5), .busy(busy5)
    );

    task automatic chk(input string name, input int unsigned got, input int unsigned exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (edge %0d)", name, cyc);
    endtask

    // Reference model: a window spans the edges (ws, ws+GATE]; its result is
    // the number of sigin rises whose detection edge (two edges after being
    // sampled) lies inside that span.
    initial begin
        exp_t        e;
        int unsigned n;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                prev_s = 1;
                in_win = 0;
            end else begin
                if (sigin && !prev_s) rises.push_back(cyc);
                prev_s = sigin;
                if (!in_win) begin
                    if (enable) begin
                        in_win = 1;
                        ws = cyc;
                    end
                end else if (!enable) begin
                    in_win = 0;
                end else if (cyc == ws + GATE) begin
                    n = 0;
                    foreach (rises[i])
                        if (rises[i] + 2 > ws && rises[i] + 2 <= cyc) n++;
                    e.n = n;
                    e.due = cyc;
                    q8.push_back(e);
                    q5.push_back(e);
                    ws = cyc;
                end
            end
        end
    end

    // Monitor: pops expected results when the DUTs pulse count_valid and
    // checks held outputs and busy every cycle.
    initial begin
        exp_t        e;
        int unsigned h8 = 0, ho8 = 0, h5 = 0, ho5 = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                h8 = 0; ho8 = 0; h5 = 0; ho5 = 0;
            end
            chk("busy8", busy8, rst_n ? in_win : 0);
            chk("busy5", busy5, rst_n ? in_win : 0);

            while (q8.size() > 0 && q8[0].due < cyc) begin
                fail_now("missing_valid8");
                void'(q8.pop_front());
            end
            if (v8) begin
                if (q8.size() > 0 && q8[0].due == cyc) begin
                    e = q8.pop_front();
                    h8 = (e.n > 255) ? 255 : e.n;
                    ho8 = (e.n > 255) ? 1 : 0;
                end else begin
                    fail_now("unexpected_valid8");
                end
            end
            chk("count8", count8, h8);
            chk("ovf8", ovf8, ho8);

            while (q5.size() > 0 && q5[0].due < cyc) begin
                fail_now("missing_valid5");
                void'(q5.pop_front());
            end
            if (v5) begin
                if (q5.size() > 0 && q5[0].due == cyc) begin
                    e = q5.pop_front();
                    h5 = (e.n > 31) ? 31 : e.n;
                    ho5 = (e.n > 31) ? 1 : 0;
                end else begin
                    fail_now("unexpected_valid5");
                end
            end
            chk("count5", count5, h5);
            chk("ovf5", ovf5, ho5);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic run_sq(input int unsigned hp, input int unsigned cycles);
        int unsigned c = 0;
        for (int unsigned i = 0; i < cycles; i++) begin
            step();
            c++;
            if (c >= hp) begin
                sigin = ~sigin;
                c = 0;
            end
        end
    endtask

    task automatic wait_gate(input int unsigned off, input string name, output bit ok);
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            if (in_win && cyc == ws + off) begin
                ok = 1;
                break;
            end
            step();
        end
        if (!ok) fail_now(name);
    endtask

    initial begin
        bit          ok;
        int unsigned hp, cnt, en_off;

        // 1: reset with sigin and enable high, sigin stays high
        sigin = 1; enable = 1; rst_n = 0;
        step(); step(); step();
        chk("reset_count", count8, 0);
        chk("reset_busy", busy8, 0);
        chk("reset_valid", v8, 0);
        rst_n = 1;
        run_sq(1000, 250);

        // 2: clkin/10 square wave
        sigin = 0;
        run_sq(5, 350);

        // 3: clkin/2 toggle saturates the 5-bit counter, then slow again
        run_sq(1, 250);
        run_sq(5, 300);

        // 4: single pulse detected in the last gate cycle
        sigin = 0;
        run_sq(1000, 10);
        wait_gate(GATE - 3, "timeout_last_cycle_pulse", ok);
        sigin = 1;
        step(); step(); step();
        sigin = 0;
        run_sq(1000, 250);

        // 5: abort at gc==50, then re-enable; abort at window-end cycle
        wait_gate(50, "timeout_abort_mid", ok);
        enable = 0;
        step();
        chk("busy_after_abort", busy8, 0);
        run_sq(5, 20);
        enable = 1;
        run_sq(5, 120);
        wait_gate(GATE - 1, "timeout_abort_end", ok);
        enable = 0;
        step();
        enable = 1;
        run_sq(5, 130);

        // 6: asynchronous reset mid-window
        wait_gate(40, "timeout_reset_mid", ok);
        chk("count_before_reset", count8, 10);
        rst_n = 0;
        #1;
        chk("async_reset_count", count8, 0);
        chk("async_reset_busy", busy8, 0);
        chk("async_reset_ovf", ovf8, 0);
        step(); step();
        rst_n = 1;
        step();
        chk("busy_after_release", busy8, 1);
        run_sq(5, 250);

        // 7: randomized rates, aborts and resets
        hp = 3; cnt = 0; en_off = 0;
        for (int unsigned i = 0; i < 5000; i++) begin
            step();
            cnt++;
            if (cnt >= hp) begin
                sigin = ~sigin;
                cnt = 0;
                if ($urandom_range(0, 15) == 0) hp = $urandom_range(1, 12);
            end
            if (en_off > 0) begin
                en_off--;
                if (en_off == 0) enable = 1;
            end else if ($urandom_range(0, 399) == 0) begin
                enable = 0;
                en_off = $urandom_range(1, 30);
            end
            if ($urandom_range(0, 1999) == 0) begin
                rst_n = 0;
                step(); step();
                rst_n = 1;
            end
        end
        enable = 0;
        run_sq(1000, 5);
        chk("queue8_drained", q8.size(), 0);
        chk("queue5_drained", q5.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
